// File: rtl/seq_ser_tx.sv
// rtl/seq_ser_tx.sv - parallel-to-serial word transmitter, MSB first, with inter-word gap.
// Optional even-parity beat after the LSB when SEQ_SER_TX_PARITY_EN is defined.
module seq_ser_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef SEQ_SER_TX_PARITY_EN
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
`endif
    localparam logic [7:0] GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state, state_n;
    logic             hold_full, hold_full_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    bit_cnt, bit_cnt_n;
    logic [7:0]       gap_cnt, gap_cnt_n;
    logic             load;
    logic             accept;
`ifdef SEQ_SER_TX_PARITY_EN
    logic             par, par_n;
`endif

    assign din_ready = !hold_full && !rst;
    assign accept    = din_valid && din_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold_full <= 1'b0;
            hold      <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
`ifdef SEQ_SER_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            hold_full <= hold_full_n;
            hold      <= hold_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_cnt_n;
            gap_cnt   <= gap_cnt_n;
`ifdef SEQ_SER_TX_PARITY_EN
            par       <= par_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        hold_full_n = hold_full;
        hold_n      = hold;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        gap_cnt_n   = gap_cnt;
        load        = 1'b0;
`ifdef SEQ_SER_TX_PARITY_EN
        par_n       = par;
`endif
        case (state)
            ST_IDLE: begin
                // Loading from the buffer does not wait for en.
                if (hold_full) begin
                    load    = 1'b1;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (en) begin
                    if (bit_cnt == LAST_BIT) begin
                        if (GAP > 0) begin
                            state_n   = ST_GAP;
                            gap_cnt_n = GAP_LOAD;
                        end else if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        shreg_n   = {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt_n = bit_cnt + CW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (en) begin
                    if (gap_cnt == 8'd0) begin
                        if (hold_full) begin
                            load    = 1'b1;
                            state_n = ST_SHIFT;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        gap_cnt_n = gap_cnt - 8'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (load) begin
            shreg_n     = hold;
            bit_cnt_n   = '0;
            hold_full_n = 1'b0;
`ifdef SEQ_SER_TX_PARITY_EN
            par_n       = ^hold;
`endif
        end
        // accept needs an empty buffer and load needs a full one, so they never collide.
        if (accept) begin
            hold_full_n = 1'b1;
            hold_n      = din;
        end
    end

    always_comb begin
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        if (state == ST_SHIFT) begin
            ser_valid = en;
`ifdef SEQ_SER_TX_PARITY_EN
            ser_out   = (bit_cnt == CW'(WIDTH)) ? par : shreg[WIDTH-1];
`else
            ser_out   = shreg[WIDTH-1];
`endif
        end
    end

    assign frame_start = ser_valid && (bit_cnt == '0) && (state == ST_SHIFT);
    assign busy        = (state != ST_IDLE) || hold_full;

endmodule
